dvi_pixel_expander: RTL

- Downstream consumer of the display-plane FIFO; sits between that FIFO and the DVI/TMDS encoder.
- The frame-buffer address generator writes one 8-bit RGB332 word per low-res pixel; each 80-word row is written 8 times, giving 480 output lines.
- This block pops one word per SCALE active DVI pixel clocks, so each word becomes 8 horizontal pixels. It expands RGB332 to RGB888 and outputs black outside the valid region.
- It flags underflow and frame misalignment.

---
 rtl/dvi_pkg.sv | 32 +++
 rtl/dvi_pixel_expander_if.sv | 24 ++
 rtl/rgb332_expand.sv | 13 +
 rtl/dvi_pixel_expander.sv | 126 ++++++++++++
 4 files changed

// File: rtl/dvi_pkg.sv
// Shared constants, FSM state type and RGB332->RGB888 expansion for the
// DVI pixel expander and the test-pattern path.
package dvi_pkg;

  localparam int unsigned DATA_W = 8;    // FIFO word: [7:5]=R [4:2]=G [1:0]=B
  localparam int unsigned COLS   = 80;   // low-res pixels per line
  localparam int unsigned ROWS   = 480;  // output lines per frame
  localparam int unsigned SCALE  = 8;    // horizontal repeat per word, power of two
  localparam int unsigned RGB_W  = 24;

  localparam int unsigned SUB_W  = $clog2(SCALE);
  localparam int unsigned COL_W  = $clog2(COLS + 1);
  localparam int unsigned ROW_W  = $clog2(ROWS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FRAME = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Bit replication spreads each channel over the full 0..255 range.
  function automatic logic [RGB_W-1:0] rgb332_to_888(input logic [DATA_W-1:0] w);
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    r = w[7:5];
    g = w[4:2];
    b = w[1:0];
    return {r, r, r[2:1], g, g, g[2:1], b, b, b, b};
  endfunction

endpackage

// File: rtl/dvi_pixel_expander_if.sv
// FIFO read-side bus between the display-plane FIFO and the pixel expander.
//   fifo_empty : FIFO empty flag (first-word-fall-through)
//   fifo_data  : head word, valid whenever fifo_empty=0
//   fifo_rd_en : pop strobe from the consumer
// master = consumer (expander), slave = FIFO.
interface dvi_pixel_expander_if;

  logic                        fifo_empty;
  logic [dvi_pkg::DATA_W-1:0]  fifo_data;
  logic                        fifo_rd_en;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd_en
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_rd_en
  );

endinterface

// File: rtl/rgb332_expand.sv
// Combinational RGB332 -> RGB888 expander.
//   data_i : packed RGB332 word
//   rgb_o  : RGB888 pixel {R8, G8, B8}
module rgb332_expand
  import dvi_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  output logic [RGB_W-1:0]  rgb_o
);

  assign rgb_o = rgb332_to_888(data_i);

endmodule

// File: rtl/dvi_pixel_expander.sv
// Pops RGB332 words from the display-plane FIFO, repeats each word for SCALE
// active pixel clocks, expands it to RGB888 and forwards it to the TMDS
// encoder. Tracks column/row against the DVI raster and flags underflow and
// frame misalignment.
//   clk, rst_n  : pixel clock, synchronous active-low reset
//   frame_start : one-cycle start-of-frame pulse from the timing generator
//   active      : display enable from the timing generator
//   fifo        : FIFO read bus (master side; fifo_rd_en is combinational)
//   pixel_rgb   : registered RGB888 pixel, 1 clk after active/fifo_data
//   pixel_de    : registered copy of active
//   underflow   : sticky, pop required while the FIFO was empty
//   frame_err   : sticky, frame_start mid-frame or short line
module dvi_pixel_expander
  import dvi_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        frame_start,
  input  logic                        active,
  dvi_pixel_expander_if.master        fifo,
  output logic [RGB_W-1:0]            pixel_rgb,
  output logic                        pixel_de,
  output logic                        underflow,
  output logic                        frame_err
);

  state_e            state_q;
  logic [SUB_W-1:0]  sub_x_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic              active_q;
  logic [RGB_W-1:0]  pixel_rgb_q;
  logic              pixel_de_q;
  logic              underflow_q;
  logic              frame_err_q;

  logic [RGB_W-1:0]  expand_rgb;
  logic [RGB_W-1:0]  pixel_rgb_d;
  logic              in_line_c;
  logic              word_end_c;
  logic              line_end_c;
  logic              pop_c;

  rgb332_expand u_expand (
    .data_i (fifo.fifo_data),
    .rgb_o  (expand_rgb)
  );

  // Cycle classification; frame_start always wins over pixel work.
  always_comb begin
    in_line_c   = 1'b0;
    word_end_c  = 1'b0;
    line_end_c  = 1'b0;
    pop_c       = 1'b0;
    pixel_rgb_d = '0;
    if (state_q == S_FRAME && !frame_start) begin
      in_line_c  = active && (col_q < COL_W'(COLS));
      line_end_c = !active && active_q;
    end
    word_end_c = (sub_x_q == SUB_W'(SCALE - 1));
    // Gated by rst_n so nothing is popped on the reset edge.
    pop_c = rst_n && in_line_c && word_end_c && !fifo.fifo_empty;
    if (in_line_c && !fifo.fifo_empty) begin
      pixel_rgb_d = expand_rgb;
    end
  end

  assign fifo.fifo_rd_en = pop_c;

  // State, raster counters, pixel pipeline and sticky flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sub_x_q     <= '0;
      col_q       <= '0;
      row_q       <= '0;
      active_q    <= 1'b0;
      pixel_rgb_q <= '0;
      pixel_de_q  <= 1'b0;
      underflow_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      pixel_de_q  <= active;
      pixel_rgb_q <= pixel_rgb_d;
      if (frame_start) begin
        if (state_q == S_FRAME && row_q != '0) begin
          frame_err_q <= 1'b1;
        end
        state_q  <= S_FRAME;
        sub_x_q  <= '0;
        col_q    <= '0;
        row_q    <= '0;
        active_q <= 1'b0;
      end else if (state_q == S_FRAME) begin
        active_q <= active;
        if (in_line_c) begin
          // SCALE is a power of two, so sub_x wraps on its own.
          sub_x_q <= sub_x_q + SUB_W'(1);
          if (word_end_c) begin
            col_q <= col_q + COL_W'(1);
            // A missed word is dropped; counters stay locked to the raster.
            if (fifo.fifo_empty) begin
              underflow_q <= 1'b1;
            end
          end
        end else if (line_end_c) begin
          if (col_q != COL_W'(COLS)) begin
            frame_err_q <= 1'b1;
          end
          sub_x_q <= '0;
          col_q   <= '0;
          row_q   <= row_q + ROW_W'(1);
          if (row_q == ROW_W'(ROWS - 1)) begin
            state_q <= S_DONE;
          end
        end
      end
    end
  end

  assign pixel_rgb = pixel_rgb_q;
  assign pixel_de  = pixel_de_q;
  assign underflow = underflow_q;
  assign frame_err = frame_err_q;

endmodule
